// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control: sequences FETCH/DECODE/EXEC/MEM/WB, decodes per-state datapath
// strobes, bounds memory waits with a timeout and counts retired instructions.
module multicycle_control_fsm #(
  parameter int unsigned ALUOP_W   = 2,
  parameter int unsigned TMO_W     = 4,
  parameter int unsigned MEM_TMO   = 15,
  parameter int unsigned RET_W     = 32,
  parameter bit          TRAP_HALT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               pc_write,
  output logic               ir_write,
  output logic               branch,
  output logic               jump,
  output logic               memread,
  output logic               memwrite,
  output logic               memtoreg,
  output logic               alusrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               regwrite,
  output logic               illegal,
  output logic [2:0]         state,
  output logic [RET_W-1:0]   retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [2:0] {ClsR, ClsLd, ClsSt, ClsB, ClsImm, ClsJalr, ClsJal} cls_e;

  state_e             state_q, state_d;
  cls_e               cls_q, cls_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               illegal_q, illegal_d;
  logic [RET_W-1:0]   ret_q, ret_d;
  logic               fbusy_q, fbusy_d;
  logic               fetch_act;
  logic               tmo_hit;
  logic [1:0]         aluop_c;

  // Once a fetch has started it stays requested until the memory answers, even if run drops.
  assign fetch_act = run | fbusy_q;
  assign tmo_hit   = (tmo_q == TMO_W'(MEM_TMO - 1));

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    tmo_d     = tmo_q;
    illegal_d = illegal_q;
    ret_d     = ret_q;
    fbusy_d   = fbusy_q;
    unique case (state_q)
      StFetch: begin
        if (fetch_act) begin
          if (mem_ready) begin
            state_d = StDecode;
            fbusy_d = 1'b0;
          end else if (tmo_hit) begin
            state_d   = StTrap;
            illegal_d = 1'b1;
            fbusy_d   = 1'b0;
          end else begin
            tmo_d   = tmo_q + TMO_W'(1);
            fbusy_d = 1'b1;
          end
        end
      end
      StDecode: begin
        state_d = StExec;
        case (opcode)
          7'b0110011: cls_d = ClsR;
          7'b0000011: cls_d = ClsLd;
          7'b0100011: cls_d = ClsSt;
          7'b1100011: cls_d = ClsB;
          7'b0010011: cls_d = ClsImm;
          7'b1100111: cls_d = ClsJalr;
          7'b1101111: cls_d = ClsJal;
          default: begin
            state_d   = StTrap;
            illegal_d = 1'b1;
          end
        endcase
      end
      StExec: begin
        if (cls_q == ClsB) begin
          state_d = StFetch;
          ret_d   = ret_q + RET_W'(1);
        end else if (cls_q == ClsLd || cls_q == ClsSt) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (mem_ready) begin
          if (cls_q == ClsSt) begin
            state_d = StFetch;
            ret_d   = ret_q + RET_W'(1);
          end else begin
            state_d = StWb;
          end
        end else if (tmo_hit) begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      StWb: begin
        state_d = StFetch;
        ret_d   = ret_q + RET_W'(1);
      end
      StTrap: begin
        if (!TRAP_HALT) state_d = StFetch;
      end
      default: state_d = StTrap;
    endcase
    // Every state change is an entry into a fresh wait window.
    if (state_d != state_q) tmo_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      tmo_q     <= '0;
      illegal_q <= 1'b0;
      ret_q     <= '0;
      fbusy_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      tmo_q     <= tmo_d;
      illegal_q <= illegal_d;
      ret_q     <= ret_d;
      fbusy_q   <= fbusy_d;
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    pc_write = 1'b0;
    ir_write = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    alusrc   = 1'b0;
    aluop_c  = 2'b00;
    regwrite = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req  = fetch_act;
        memread  = fetch_act;
        ir_write = fetch_act & mem_ready;
        pc_write = fetch_act & mem_ready;
      end
      StExec: begin
        unique case (cls_q)
          ClsR:   aluop_c = 2'b10;
          ClsImm: begin aluop_c = 2'b10; alusrc = 1'b1; end
          ClsLd, ClsSt: alusrc = 1'b1;
          ClsB:   begin aluop_c = 2'b01; branch = 1'b1; end
          ClsJal: begin aluop_c = 2'b11; jump = 1'b1; memtoreg = 1'b1; end
          ClsJalr: begin
            aluop_c  = 2'b11;
            jump     = 1'b1;
            memtoreg = 1'b1;
            alusrc   = 1'b1;
          end
          default: aluop_c = 2'b00;
        endcase
      end
      StMem: begin
        mem_req  = 1'b1;
        memread  = (cls_q == ClsLd);
        memwrite = (cls_q == ClsSt);
      end
      StWb: begin
        regwrite = 1'b1;
        memtoreg = (cls_q == ClsLd) || (cls_q == ClsJal) || (cls_q == ClsJalr);
      end
      default: mem_req = 1'b0;
    endcase
  end

  assign aluop   = ALUOP_W'(aluop_c);
  assign illegal = illegal_q;
  assign state   = state_q;
  assign retired = ret_q;

endmodule
